// File: rtl/sram_arbiter.sv
// Arbitrates one SRAM port between pipelined pixel reads, the ADC pixel stream and a buffered SPI writer.
// Optional macro SRAM_ARB_SPI_PRIO_EN lets a full SPI FIFO take precedence over pending ADC pixels.
module sram_arbiter #(
    parameter int X_RES          = 800,
    parameter int Y_RES          = 600,
    parameter int SRAM_DELAY     = 5,
    parameter int SPI_FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frozen,
    input  logic        spi_valid,
    input  logic [15:0] spi_pixel_in,
    input  logic [11:0] spi_pixel_x,
    input  logic [11:0] spi_pixel_y,
    output logic        spi_ready,
    input  logic [37:0] adc_pixel_data,
    input  logic        adc_pixel_ready,
    output logic        adc_pixel_read,
    input  logic        request_active,
    input  logic [11:0] request_x,
    input  logic [11:0] request_y,
    output logic [15:0] request_data,
    output logic        request_ready,
    output logic        sram_we,
    output logic [19:0] sram_addr,
    output logic [16:0] sram_data_in,
    input  logic [16:0] sram_data_out,
    output logic        frozen_active
);

    localparam int PTR_W = $clog2(SPI_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_LIVE        = 2'd0;
    localparam logic [1:0] ST_FREEZE_PEND = 2'd1;
    localparam logic [1:0] ST_FROZEN      = 2'd2;
    localparam logic [1:0] ST_THAW_PEND   = 2'd3;

    function automatic logic coord_ok(input logic signed [11:0] x, input logic signed [11:0] y);
        int xi;
        int yi;
        xi = int'(x);
        yi = int'(y);
        return (xi >= 0) && (xi < X_RES) && (yi >= 0) && (yi < Y_RES);
    endfunction

    // SPI FIFO: the head must be visible in the grant cycle, so the array is read combinationally
    logic [39:0]      fifo_mem [SPI_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_full, fifo_empty, spi_push;
    logic [39:0]      fifo_head;

    logic [1:0]  state_q, state_d;
    logic        sram_we_q, sram_we_d;
    logic [19:0] sram_addr_q, sram_addr_d;
    logic [16:0] sram_data_q, sram_data_d;
    logic [SRAM_DELAY:0] vld_q, vld_d, inb_q, inb_d;

    logic        adc_eligible, grant_read, grant_adc, grant_spi;
    logic        req_inb, adc_inb, spi_inb, frame_start, adc_wr_en;
    logic [10:0] adc_x, adc_y;
    logic        unused_bits;

    assign fifo_full  = (count_q == CNT_W'(SPI_FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign spi_ready  = !fifo_full;
    assign spi_push   = spi_valid && spi_ready;
    assign fifo_head  = fifo_mem[rd_ptr_q];

    assign adc_x = adc_pixel_data[37:27];
    assign adc_y = adc_pixel_data[26:16];

    assign req_inb = coord_ok(request_x, request_y);
    assign adc_inb = coord_ok({1'b0, adc_x}, {1'b0, adc_y});
    assign spi_inb = coord_ok(fifo_head[39:28], fifo_head[27:16]);

`ifdef SRAM_ARB_SPI_PRIO_EN
    assign adc_eligible = adc_pixel_ready && !fifo_full;
`else
    assign adc_eligible = adc_pixel_ready;
`endif

    assign grant_read     = request_active;
    assign grant_adc      = !request_active && adc_eligible;
    assign grant_spi      = !request_active && !grant_adc && !fifo_empty;
    assign adc_pixel_read = grant_adc;
    assign frame_start    = grant_adc && (adc_x == '0) && (adc_y == '0);

    // Freeze takes effect on a frame boundary; the boundary pixel follows the state being entered
    always_comb begin
        state_d   = state_q;
        adc_wr_en = 1'b0;
        case (state_q)
            ST_LIVE: begin
                adc_wr_en = 1'b1;
                if (frozen) state_d = ST_FREEZE_PEND;
            end
            ST_FREEZE_PEND: begin
                adc_wr_en = !(frame_start && frozen);
                if (!frozen)          state_d = ST_LIVE;
                else if (frame_start) state_d = ST_FROZEN;
            end
            ST_FROZEN: begin
                if (!frozen) state_d = ST_THAW_PEND;
            end
            ST_THAW_PEND: begin
                adc_wr_en = frame_start && !frozen;
                if (frozen)           state_d = ST_FROZEN;
                else if (frame_start) state_d = ST_LIVE;
            end
            default: state_d = ST_LIVE;
        endcase
    end

    always_comb begin
        sram_we_d   = 1'b0;
        sram_addr_d = sram_addr_q;
        sram_data_d = sram_data_q;
        if (grant_read) begin
            if (req_inb) sram_addr_d = {request_x[9:0], request_y[9:0]};
        end else if (grant_adc) begin
            if (adc_inb && adc_wr_en) begin
                sram_we_d   = 1'b1;
                sram_addr_d = {adc_x[9:0], adc_y[9:0]};
                sram_data_d = {1'b0, adc_pixel_data[15:0]};
            end
        end else if (grant_spi) begin
            if (spi_inb) begin
                sram_we_d   = 1'b1;
                sram_addr_d = {fifo_head[37:28], fifo_head[25:16]};
                sram_data_d = {1'b0, fifo_head[15:0]};
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (spi_push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (grant_spi) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (spi_push && !grant_spi)      count_d = count_q + CNT_W'(1);
        else if (!spi_push && grant_spi) count_d = count_q - CNT_W'(1);
    end

    // Read tracking pipeline: stage SRAM_DELAY lines up with the returned SRAM word
    genvar gi;
    generate
        for (gi = 0; gi <= SRAM_DELAY; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign vld_d[gi] = grant_read;
                assign inb_d[gi] = grant_read && req_inb;
            end else begin : g_tail
                assign vld_d[gi] = vld_q[gi-1];
                assign inb_d[gi] = inb_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (spi_push) fifo_mem[wr_ptr_q] <= {spi_pixel_x, spi_pixel_y, spi_pixel_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LIVE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sram_we_q   <= 1'b0;
            sram_addr_q <= '0;
            sram_data_q <= '0;
            vld_q       <= '0;
            inb_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            sram_we_q   <= sram_we_d;
            sram_addr_q <= sram_addr_d;
            sram_data_q <= sram_data_d;
            vld_q       <= vld_d;
            inb_q       <= inb_d;
        end
    end

    assign request_ready = vld_q[SRAM_DELAY];
    assign request_data  = (vld_q[SRAM_DELAY] && inb_q[SRAM_DELAY]) ? sram_data_out[15:0] : 16'h0000;
    assign sram_we       = sram_we_q;
    assign sram_addr     = sram_addr_q;
    assign sram_data_in  = sram_data_q;
    assign frozen_active = (state_q == ST_FROZEN) || (state_q == ST_THAW_PEND);
    assign unused_bits   = sram_data_out[16];

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios then random traffic against a cycle-level reference model.
module tb_sram_arbiter;

    localparam int X_RES = 800;
    localparam int Y_RES = 600;
    localparam int D     = 5;
    localparam int DEPTH = 16;
`ifdef SRAM_ARB_SPI_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        frozen;
    logic        spi_valid;
    logic [15:0] spi_pixel_in;
    logic [11:0] spi_pixel_x, spi_pixel_y;
    logic        spi_ready;
    logic [37:0] adc_pixel_data;
    logic        adc_pixel_ready, adc_pixel_read;
    logic        request_active;
    logic [11:0] request_x, request_y;
    logic [15:0] request_data;
    logic        request_ready;
    logic        sram_we;
    logic [19:0] sram_addr;
    logic [16:0] sram_data_in;
    logic [16:0] sram_data_out;
    logic        frozen_active;

    always #5 clk = ~clk;

    sram_arbiter #(.X_RES(X_RES), .Y_RES(Y_RES), .SRAM_DELAY(D), .SPI_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .frozen(frozen),
        .spi_valid(spi_valid), .spi_pixel_in(spi_pixel_in), .spi_pixel_x(spi_pixel_x),
        .spi_pixel_y(spi_pixel_y), .spi_ready(spi_ready),
        .adc_pixel_data(adc_pixel_data), .adc_pixel_ready(adc_pixel_ready), .adc_pixel_read(adc_pixel_read),
        .request_active(request_active), .request_x(request_x), .request_y(request_y),
        .request_data(request_data), .request_ready(request_ready),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_data_in(sram_data_in),
        .sram_data_out(sram_data_out), .frozen_active(frozen_active)
    );

    typedef enum {M_LIVE, M_FP, M_FROZEN, M_TP} fst_t;
    typedef struct { int due; logic [15:0] data; } rd_t;

    int          cycle = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    rd_t         rdq [$];
    logic [39:0] fifo_m [$];
    fst_t        mst;
    logic        m_we;
    logic [19:0] m_addr;
    logic [16:0] m_data;
    logic [19:0] hist [16];
    logic        const_en = 1'b0;
    logic [16:0] const_val = 17'h0;

    // SRAM contents as seen by the bench: a fixed scramble of the address
    function automatic logic [15:0] hash(input logic [19:0] a);
        return a[15:0] ^ 16'h5A3C ^ {a[19:16], 12'h0};
    endfunction

    function automatic bit in_b(input int x, input int y);
        return (x >= 0) && (x < X_RES) && (y >= 0) && (y < Y_RES);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cycle, obs, exp);
        end
    endtask

    task automatic set_idle();
        request_active = 1'b0; adc_pixel_ready = 1'b0; spi_valid = 1'b0;
    endtask

    // Move to the next negedge and present the SRAM word addressed D cycles earlier
    task automatic advance();
        @(posedge clk);
        @(negedge clk);
        for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = sram_addr;
        sram_data_out = const_en ? const_val : {1'b0, hash(hist[D])};
        cycle++;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        advance();
        advance();
        rst = 1'b0;
        rdq.delete();
        fifo_m.delete();
        mst = M_LIVE; m_we = 1'b0; m_addr = '0; m_data = '0;
    endtask

    task automatic step();
        bit full, g_read, g_adc, g_spi, e_rdy, wr, fs, inb;
        logic [15:0] e_rdata;
        logic [19:0] a;
        logic [10:0] ax, ay;
        logic [39:0] ent;
        int xi, yi;
        fst_t nst;
        rd_t r;
        #1;
        full   = (fifo_m.size() == DEPTH);
        g_read = request_active;
        g_adc  = !g_read && adc_pixel_ready && !(PRIO && full);
        g_spi  = !g_read && !g_adc && (fifo_m.size() != 0);
        e_rdy  = (rdq.size() > 0) && (rdq[0].due == cycle);
        e_rdata = e_rdy ? rdq[0].data : 16'h0000;
        if (e_rdy) void'(rdq.pop_front());

        chk("adc_pixel_read", adc_pixel_read, g_adc);
        chk("spi_ready", spi_ready, !full);
        chk("frozen_active", frozen_active, (mst == M_FROZEN) || (mst == M_TP));
        chk("sram_we", sram_we, m_we);
        chk("sram_addr", sram_addr, m_addr);
        chk("sram_data_in", sram_data_in, m_data);
        chk("request_ready", request_ready, e_rdy);
        chk("request_data", request_data, e_rdata);

        ax = adc_pixel_data[37:27];
        ay = adc_pixel_data[26:16];
        fs = g_adc && (ax == 0) && (ay == 0);
        if (frozen) nst = (mst == M_LIVE) ? M_FP : (mst == M_FP) ? (fs ? M_FROZEN : M_FP) : M_FROZEN;
        else        nst = (mst == M_FROZEN) ? M_TP : (mst == M_TP) ? (fs ? M_LIVE : M_TP) : M_LIVE;
        wr = (nst == M_LIVE) || (nst == M_FP);

        m_we = 1'b0;
        if (g_read) begin
            xi = $signed(request_x);
            yi = $signed(request_y);
            inb = in_b(xi, yi);
            a = {request_x[9:0], request_y[9:0]};
            if (inb) m_addr = a;
            r.due  = cycle + D + 1;
            r.data = inb ? (const_en ? const_val[15:0] : hash(a)) : 16'h0000;
            rdq.push_back(r);
        end else if (g_adc) begin
            if (wr && in_b(int'(ax), int'(ay))) begin
                m_we = 1'b1; m_addr = {ax[9:0], ay[9:0]}; m_data = {1'b0, adc_pixel_data[15:0]};
            end
        end else if (g_spi) begin
            ent = fifo_m.pop_front();
            xi = $signed(ent[39:28]);
            yi = $signed(ent[27:16]);
            if (in_b(xi, yi)) begin
                m_we = 1'b1; m_addr = {ent[37:28], ent[25:16]}; m_data = {1'b0, ent[15:0]};
            end
        end
        if (spi_valid && !full) fifo_m.push_back({spi_pixel_x, spi_pixel_y, spi_pixel_in});
        mst = nst;
        advance();
    endtask

    task automatic read_px(input int x, input int y);
        request_active = 1'b1; request_x = 12'(x); request_y = 12'(y);
        step();
        request_active = 1'b0;
    endtask

    task automatic adc_px(input int x, input int y);
        adc_pixel_ready = 1'b1;
        adc_pixel_data = {11'(x), 11'(y), 16'(16'hC000 + x * 7 + y)};
        step();
        adc_pixel_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        set_idle();
        repeat (n) step();
    endtask

    initial begin
        rst = 1'b1; frozen = 1'b0;
        spi_pixel_in = '0; spi_pixel_x = '0; spi_pixel_y = '0;
        adc_pixel_data = '0; request_x = '0; request_y = '0;
        sram_data_out = '0;
        for (int i = 0; i < 16; i++) hist[i] = '0;
        set_idle();
        @(negedge clk);
        do_reset();
        idle(2);

        // single in-bounds read with a fixed SRAM word, then out-of-bounds reads
        const_en = 1'b1; const_val = 17'h0ABCD;
        idle(D + 1);
        read_px(10, 20);
        idle(D + 2);
        read_px(800, 5);
        read_px(-1, 5);
        read_px(799, 599);
        read_px(5, 600);
        idle(D + 3);
        const_en = 1'b0;
        idle(D + 1);

        // fully pipelined read burst
        for (int i = 0; i < 8; i++) read_px(i * 97, 599 - i * 50);
        idle(D + 2);

        // reads block a waiting ADC pixel, which pops once they stop
        adc_pixel_ready = 1'b1; adc_pixel_data = {11'd33, 11'd44, 16'h1234};
        request_active = 1'b1; request_x = 12'd1; request_y = 12'd2;
        repeat (3) step();
        request_active = 1'b0;
        step();
        idle(D + 2);

        // freeze requested mid-frame, thaw on a later frame
        adc_px(5, 5); adc_px(6, 5);
        frozen = 1'b1;
        adc_px(7, 5); adc_px(8, 5); adc_px(0, 0); adc_px(1, 0); adc_px(2, 0);
        frozen = 1'b0;
        adc_px(3, 0); adc_px(4, 0); adc_px(0, 0); adc_px(1, 0);
        frozen = 1'b1; adc_px(2, 0);
        frozen = 1'b0; adc_px(3, 0);
        idle(3);

        // fill the SPI FIFO past capacity while reads block everything
        adc_pixel_ready = 1'b1; adc_pixel_data = {11'd9, 11'd9, 16'h0F0F};
        request_active = 1'b1; request_x = 12'd3; request_y = 12'd4;
        for (int i = 0; i < 17; i++) begin
            spi_valid = 1'b1; spi_pixel_x = 12'(i * 50); spi_pixel_y = 12'd3;
            spi_pixel_in = 16'(16'hA000 + i);
            step();
        end
        spi_valid = 1'b0; request_active = 1'b0;
        repeat (4) step();
        idle(DEPTH + D + 2);

        // out-of-bounds SPI pixels are discarded
        spi_valid = 1'b1;
        spi_pixel_x = 12'hFFF; spi_pixel_y = 12'd1; spi_pixel_in = 16'h1111; step();
        spi_pixel_x = 12'd1; spi_pixel_y = 12'd600; spi_pixel_in = 16'h2222; step();
        spi_pixel_x = 12'd2; spi_pixel_y = 12'd2; spi_pixel_in = 16'h3333; step();
        idle(5);

        // reads in flight at reset never complete
        read_px(11, 12); read_px(13, 14); read_px(15, 16);
        do_reset();
        idle(D + 4);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            request_active = ($urandom_range(0, 99) < 25);
            request_x = 12'(int'($urandom_range(0, 900)) - 40);
            request_y = 12'(int'($urandom_range(0, 700)) - 40);
            adc_pixel_ready = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 99) < 10) adc_pixel_data = {22'h0, 16'($urandom)};
            else adc_pixel_data = {11'($urandom_range(0, 850)), 11'($urandom_range(0, 650)), 16'($urandom)};
            spi_valid = ($urandom_range(0, 99) < 45);
            spi_pixel_x = 12'(int'($urandom_range(0, 900)) - 40);
            spi_pixel_y = 12'(int'($urandom_range(0, 700)) - 40);
            spi_pixel_in = 16'($urandom);
            if ($urandom_range(0, 99) < 3) frozen = ~frozen;
            step();
        end
        idle(DEPTH + D + 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter X_RES, default 800, visible width in pixels.
REQ-002 SHALL have parameter Y_RES, default 600, visible height in pixels.
REQ-003 SHALL have parameter SRAM_DELAY, default 5, sram_interface read latency in cycles (>=2).
REQ-004 SHALL have parameter SPI_FIFO_DEPTH, default 16, SPI write FIFO entries (power of two).
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 frozen  in  1  freeze-frame request, level.
REQ-008 spi_valid  in  1  SPI pixel offered.
REQ-009 spi_pixel_in  in  16  SPI pixel colour.
REQ-010 spi_pixel_x  in  12  signed SPI pixel x.
REQ-011 spi_pixel_y  in  12  signed SPI pixel y.
REQ-012 spi_ready  out  1  FIFO can accept; push = spi_valid & spi_ready.
REQ-013 adc_pixel_data  in  38  {x[37:27], y[26:16], colour[15:0]} from first-word-fall-through ADC FIFO.
REQ-014 adc_pixel_ready  in  1  ADC FIFO non-empty.
REQ-015 adc_pixel_read  out  1  combinational pop strobe, high exactly in ADC grant cycles.
REQ-016 request_active  in  1  pipeline read request.
REQ-017 request_x  in  12  signed read x.
REQ-018 request_y  in  12  signed read y.
REQ-019 request_data  out  16  read result.
REQ-020 request_ready  out  1  request_data valid, one-cycle pulse per request.
REQ-021 sram_we  out  1  write enable to sram_interface.
REQ-022 sram_addr  out  20  {x[9:0], y[9:0]} to sram_interface.
REQ-023 sram_data_in  out  17  {1'b0, colour} to sram_interface.
REQ-024 sram_data_out  in  17  read data from sram_interface.
REQ-025 frozen_active  out  1  high while ADC writes suppressed.

Function
REQ-026 Per-cycle grant priority SHALL be: request_active > ADC (adc_pixel_ready) > SPI (FIFO non-empty); one grant per cycle.
REQ-027 sram_we, sram_addr, sram_data_in SHALL be registered, one cycle after grant; no grant -> sram_we=0, addr/data hold.
REQ-028 Read grant: in bounds (0<=x<X_RES, 0<=y<Y_RES, signed compare) -> sram_addr updated, sram_we=0; out of bounds -> no SRAM access.
REQ-029 request_ready SHALL pulse exactly SRAM_DELAY+1 cycles after request_active sampled; request_data = sram_data_out[15:0], or 16'h0000 for out-of-bounds.
REQ-030 Back-to-back reads SHALL be fully pipelined, one result per cycle, in order.
REQ-031 ADC grant SHALL always pop the pixel; written only if in bounds and write-enabled per freeze state.
REQ-032 Freeze FSM states: LIVE, FREEZE_PEND, FROZEN, THAW_PEND; frame start = ADC pop with x=0,y=0.
REQ-033 LIVE: writes on; frozen=1 -> FREEZE_PEND.
REQ-034 FREEZE_PEND: writes on; frozen=0 -> LIVE; frame start with frozen=1 -> FROZEN, that pixel not written.
REQ-035 FROZEN: writes off; frozen=0 -> THAW_PEND.
REQ-036 THAW_PEND: writes off; frozen=1 -> FROZEN; frame start with frozen=0 -> LIVE, that pixel written.
REQ-037 frozen_active SHALL be 1 in FROZEN and THAW_PEND only.
REQ-038 SPI FIFO: spi_ready = (count < SPI_FIFO_DEPTH); simultaneous push and pop leaves count unchanged; pointers wrap modulo depth.
REQ-039 SPI grant SHALL pop one entry; written if in bounds, else discarded; freeze does not affect SPI.

Reset
REQ-040 rst SHALL clear FIFO (spi_ready=1), FSM to LIVE, all outputs to 0, read pipeline to idle.
REQ-041 Reads in flight at reset SHALL never produce request_ready.

Configuration
REQ-042 With SRAM_ARB_SPI_PRIO_EN defined, a full SPI FIFO SHALL beat ADC (reads still highest); without it, ADC always beats SPI.

Verification
REQ-043 Read (10,20) in bounds, sram_data_out=17'h0ABCD -> sram_addr={10'd10,10'd20} next cycle, request_ready+data 16'hABCD at cycle SRAM_DELAY+1.
REQ-044 Read (800,5) and (-1,5) -> no sram access, request_ready with data 16'h0000 at same latency.
REQ-045 request_active and adc_pixel_ready held high 3 cycles -> adc_pixel_read=0 throughout, ADC pops first cycle after request drops.
REQ-046 frozen=1 mid-frame -> writes continue until (0,0) pixel popped unwritten, frozen_active=1; frozen=0 -> writes resume at next (0,0), inclusive.
REQ-047 Push 17 SPI pixels with ADC and reads idle-blocked -> spi_ready=0 after 16, 17th ignored; macro on: full FIFO wins over pending ADC.
